// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between the CPU and a host loader/debug port.
// The host gets a bounded run of cycles while the CPU is also requesting, so neither master starves.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int MAX_HOST_RUN = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int RUN_W = $clog2(MAX_HOST_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_HOST_RUN);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    owner_t           owner;
    logic [RUN_W-1:0] run;
    logic             next_host;
    logic             host_read_done;

    // Host keeps the port until it has used up its run, but only while the CPU is also waiting.
    assign next_host      = host_req && (!cpu_req || (run < RUN_MAX));
    assign host_read_done = (owner == OWN_HOST) && host_req && !host_we;

    assign host_gnt  = (owner == OWN_HOST);
    assign cpu_stall = (owner == OWN_HOST);

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_req && cpu_we;
        if (owner == OWN_HOST) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_req && host_we;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner       <= OWN_CPU;
            run         <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            if (next_host) begin
                owner <= OWN_HOST;
                run   <= (run == RUN_MAX) ? run : run + 1'b1;
            end else begin
                owner <= OWN_CPU;
                run   <= '0;
            end
            // Read data is captured from the cycle the host actually owned the port.
            host_rvalid <= host_read_done;
            if (host_read_done) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory on the shared port.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        host_req;
    logic [15:0] host_addr;
    logic        host_we;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks;
    int errors;

    logic [31:0] mem [0:255];

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(32),
        .MAX_HOST_RUN(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .cpu_we(cpu_we),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .host_req(host_req),
        .host_addr(host_addr),
        .host_we(host_we),
        .host_wdata(host_wdata),
        .host_gnt(host_gnt),
        .host_rdata(host_rdata),
        .host_rvalid(host_rvalid),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(int i);
        if (i == 16) return 32'h12345678;
        return 32'hC0DE0000 | 32'(i);
    endfunction

    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic idle();
        @(posedge clock); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
        host_req = 1'b1; host_addr = 16'h0010; host_we = 1'b0; host_wdata = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 0", host_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", cpu_stall); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 0", host_rvalid); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 00000000", host_rdata); end
        @(posedge clock); #1;
        host_req = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL release_gnt: got %b want 0", host_gnt); end
    endtask

    task automatic test_cpu_only();
        logic [15:0] exp_addr;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            cpu_req  = 1'b1;
            exp_addr = 16'h0100 + 16'(i * 3);
            cpu_addr = exp_addr;
            @(negedge clock);
            checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL cpu_only_stall[%0d]: got %b want 0", i, cpu_stall); end
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL cpu_only_addr[%0d]: got %h want %h", i, mem_addr, exp_addr); end
        end
        @(posedge clock); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_host_read();
        @(posedge clock); #1;
        cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rd_gnt_early: got %b want 0", host_gnt); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rd_gnt: got %b want 1", host_gnt); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("[TB] FAIL rd_addr: got %h want 0010", mem_addr); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rvalid_early: got %b want 0", host_rvalid); end
        @(posedge clock); #1;
        host_req = 1'b0;
        @(negedge clock);
        checks++; if (host_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_rvalid: got %b want 1", host_rvalid); end
        checks++; if (host_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rd_data: got %h want 12345678", host_rdata); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_rvalid_pulse: got %b want 0", host_rvalid); end
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rd_gnt_release: got %b want 0", host_gnt); end
        checks++; if (host_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL rd_data_hold: got %h want 12345678", host_rdata); end
    endtask

    task automatic test_fairness();
        logic exp_gnt;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0011;
        for (int i = 0; i < 12; i++) begin
            exp_gnt = ((i % 5) != 4);
            @(posedge clock);
            @(negedge clock);
            checks++; if (host_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL fair_gnt[%0d]: got %b want %b", i, host_gnt, exp_gnt); end
            checks++; if (cpu_stall !== exp_gnt) begin errors++; $display("[TB] FAIL fair_stall[%0d]: got %b want %b", i, cpu_stall, exp_gnt); end
        end
        idle();
    endtask

    task automatic test_host_write();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 32'hAAAAAAAA;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 32'hDEADBEEF;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr_gnt_early: got %b want 0", host_gnt); end
        checks++; if (mem_wdata !== 32'hAAAAAAAA) begin errors++; $display("[TB] FAIL wr_cpu_wdata: got %h want AAAAAAAA", mem_wdata); end
        checks++; if (mem_addr !== 16'h0030) begin errors++; $display("[TB] FAIL wr_cpu_addr: got %h want 0030", mem_addr); end
        @(posedge clock); #1;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b1) begin errors++; $display("[TB] FAIL wr_gnt: got %b want 1", host_gnt); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL wr_we: got %b want 1", mem_we); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_wdata: got %h want DEADBEEF", mem_wdata); end
        checks++; if (mem_addr !== 16'h0020) begin errors++; $display("[TB] FAIL wr_addr: got %h want 0020", mem_addr); end
        @(posedge clock); #1;
        host_req = 1'b0;
        @(negedge clock);
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL wr_no_rvalid: got %b want 0", host_rvalid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle_we: got %b want 0", mem_we); end
        @(posedge clock); #1;
        cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0;
        @(negedge clock);
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL wr_cpu_back: got %b want 0", host_gnt); end
        @(posedge clock); #1;
        @(posedge clock); #1;
        host_req = 1'b0;
        @(negedge clock);
        checks++; if (host_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL wr_rb_rvalid: got %b want 1", host_rvalid); end
        checks++; if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL wr_rb_data: got %h want DEADBEEF", host_rdata); end
        idle();
    endtask

    task automatic test_drop();
        for (int w = 0; w < 2; w++) begin
            @(posedge clock); #1;
            cpu_req = 1'b0; host_req = 1'b1; host_we = (w == 1);
            host_addr = 16'h0040; host_wdata = 32'h55555555;
            @(posedge clock); #1;
            host_req = 1'b0;
            @(negedge clock);
            checks++; if (host_gnt !== 1'b1) begin errors++; $display("[TB] FAIL drop_gnt[%0d]: got %b want 1", w, host_gnt); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL drop_we[%0d]: got %b want 0", w, mem_we); end
            @(posedge clock); #1;
            @(negedge clock);
            checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL drop_owner[%0d]: got %b want 0", w, host_gnt); end
            checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_rvalid[%0d]: got %b want 0", w, host_rvalid); end
            checks++; if (mem[8'h40] !== init_val(64)) begin errors++; $display("[TB] FAIL drop_mem[%0d]: got %h want %h", w, mem[8'h40], init_val(64)); end
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        logic exp_gnt;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (host_gnt !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_gnt: got %b want 0", host_gnt); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_stall: got %b want 0", cpu_stall); end
        checks++; if (host_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_rvalid: got %b want 0", host_rvalid); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_rdata: got %h want 00000000", host_rdata); end
        @(negedge clock); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_gnt = (i < 4);
            @(posedge clock);
            @(negedge clock);
            checks++; if (host_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL mid_rst_run[%0d]: got %b want %b", i, host_gnt, exp_gnt); end
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cpu_only();
        test_host_read();
        idle();
        test_fairness();
        test_host_write();
        test_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
